// File: rtl/bsg_async_ptr_gray_read.sv
// bsg_async_ptr_gray_read
// Read-side pointer logic for an asynchronous FIFO. It keeps the binary read
// pointer, a pre-incremented copy, and a registered gray pointer that is
// launched glitch-free into the write domain. Valid and count are derived
// combinationally from the already-synchronized gray write pointer.
//
// Optional feature macro: BSG_ASYNC_PTR_GRAY_READ_CHECK_EN
//   defined   -> sticky r_error_o flags a dequeue while empty, a multi-bit jump
//                on the synchronized write pointer, or an impossible count.
//   undefined -> r_error_o is tied to 0 and no checking registers exist.
//
// Handshake: r_deq_i is a request and r_valid_o is the grant. A dequeue is
// accepted on a rising r_clk_i edge only when both are 1 in that cycle. A
// request while r_valid_o=0 is ignored and all pointers hold.

module bsg_async_ptr_gray_read #(
  parameter int lg_size_p = 5
) (
  input  logic                   r_clk_i,
  input  logic                   r_reset_i,
  input  logic [lg_size_p-1:0]   w_ptr_gray_rsync_i,
  input  logic                   r_deq_i,
  output logic                   r_valid_o,
  output logic [lg_size_p-2:0]   r_addr_o,
  output logic [lg_size_p-1:0]   r_ptr_binary_r_o,
  output logic [lg_size_p-1:0]   r_ptr_gray_r_o,
  output logic [lg_size_p-1:0]   r_count_o,
  output logic                   r_error_o
);

  localparam logic [lg_size_p-1:0] one_lp  = {{(lg_size_p-1){1'b0}}, 1'b1};
  localparam logic [lg_size_p-1:0] zero_lp = '0;

  // g[i] = b[i] ^ b[i+1], g[MSB] = b[MSB]
  function automatic logic [lg_size_p-1:0] bin_to_gray(input logic [lg_size_p-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // b[MSB] = g[MSB], b[i] = b[i+1] ^ g[i]
  function automatic logic [lg_size_p-1:0] gray_to_bin(input logic [lg_size_p-1:0] g);
    logic [lg_size_p-1:0] b;
    b = '0;
    b[lg_size_p-1] = g[lg_size_p-1];
    for (int i = lg_size_p - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [lg_size_p-1:0] r_ptr_binary_q, r_ptr_binary_d;
  logic [lg_size_p-1:0] r_ptr_p1_q,     r_ptr_p1_d;
  logic [lg_size_p-1:0] r_ptr_gray_q,   r_ptr_gray_d;
  logic [lg_size_p-1:0] w_ptr_binary;
  logic                 deq_accept;

  // Status decode: valid, accepted dequeue and occupancy from current inputs
  always_comb begin
    w_ptr_binary = gray_to_bin(w_ptr_gray_rsync_i);
    r_valid_o    = (r_ptr_gray_q != w_ptr_gray_rsync_i);
    deq_accept   = r_deq_i & r_valid_o;
    r_count_o    = w_ptr_binary - r_ptr_binary_q;
  end

  // Pointer next-state: advance all three copies together on an accepted dequeue
  always_comb begin
    r_ptr_binary_d = r_ptr_binary_q;
    r_ptr_p1_d     = r_ptr_p1_q;
    r_ptr_gray_d   = r_ptr_gray_q;
    if (deq_accept) begin
      r_ptr_binary_d = r_ptr_p1_q;
      r_ptr_p1_d     = r_ptr_p1_q + one_lp;
      // Gray comes from the registered p1 copy so the launched value is a flop output
      r_ptr_gray_d   = bin_to_gray(r_ptr_p1_q);
    end
  end

  // Pointer registers; reset wins over any dequeue in the same cycle
  always_ff @(posedge r_clk_i) begin
    if (r_reset_i) begin
      r_ptr_binary_q <= zero_lp;
      r_ptr_p1_q     <= one_lp;
      r_ptr_gray_q   <= zero_lp;
    end else begin
      r_ptr_binary_q <= r_ptr_binary_d;
      r_ptr_p1_q     <= r_ptr_p1_d;
      r_ptr_gray_q   <= r_ptr_gray_d;
    end
  end

  // Output wiring: address is the low bits of the binary pointer
  always_comb begin
    r_ptr_binary_r_o = r_ptr_binary_q;
    r_ptr_gray_r_o   = r_ptr_gray_q;
    r_addr_o         = r_ptr_binary_q[lg_size_p-2:0];
  end

`ifdef BSG_ASYNC_PTR_GRAY_READ_CHECK_EN
  localparam logic [lg_size_p-1:0] half_lp = {1'b1, {(lg_size_p-1){1'b0}}};

  logic [lg_size_p-1:0] w_ptr_prev_q, w_ptr_prev_d;
  logic [lg_size_p-1:0] w_ptr_diff;
  logic                 err_empty_deq;
  logic                 err_multi_bit;
  logic                 err_overcount;
  logic                 r_error_q, r_error_d;

  // Protocol checks: empty dequeue, more than one gray bit changing, count beyond depth
  always_comb begin
    w_ptr_diff    = w_ptr_gray_rsync_i ^ w_ptr_prev_q;
    err_empty_deq = r_deq_i & ~r_valid_o;
    err_multi_bit = ((w_ptr_diff & (w_ptr_diff - one_lp)) != zero_lp);
    err_overcount = (r_count_o > half_lp);
    w_ptr_prev_d  = w_ptr_gray_rsync_i;
    r_error_d     = r_error_q | err_empty_deq | err_multi_bit | err_overcount;
  end

  // Checker registers: previous write pointer and the sticky error flag
  always_ff @(posedge r_clk_i) begin
    if (r_reset_i) begin
      w_ptr_prev_q <= zero_lp;
      r_error_q    <= 1'b0;
    end else begin
      w_ptr_prev_q <= w_ptr_prev_d;
      r_error_q    <= r_error_d;
    end
  end

  assign r_error_o = r_error_q;
`else
  assign r_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_async_ptr_gray_read.sv
// Bench for bsg_async_ptr_gray_read: directed scenarios plus random traffic,
// compared each cycle against an occupancy model built on plain integers.
module tb_bsg_async_ptr_gray_read;

  localparam int LG = 5;
  localparam int M  = 1 << LG;
  localparam int H  = M / 2;

  logic            clk;
  logic            rst_i;
  logic [LG-1:0]   w_gray_i;
  logic            deq_i;
  logic            valid_o;
  logic [LG-2:0]   addr_o;
  logic [LG-1:0]   bin_o;
  logic [LG-1:0]   gray_o;
  logic [LG-1:0]   count_o;
  logic            error_o;

  bsg_async_ptr_gray_read #(.lg_size_p(LG)) dut (
    .r_clk_i            (clk),
    .r_reset_i          (rst_i),
    .w_ptr_gray_rsync_i (w_gray_i),
    .r_deq_i            (deq_i),
    .r_valid_o          (valid_o),
    .r_addr_o           (addr_o),
    .r_ptr_binary_r_o   (bin_o),
    .r_ptr_gray_r_o     (gray_o),
    .r_count_o          (count_o),
    .r_error_o          (error_o)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // model state: number of reads and writes as plain integers mod M
  int m_rd  = 0;
  int m_wr  = 0;
  bit m_err = 1'b0;
  int m_prev_gray = 0;

  function automatic int gray_of(input int b);
    return (b ^ (b >> 1)) & (M - 1);
  endfunction

  function automatic int popcount(input int x);
    int c;
    c = 0;
    for (int i = 0; i < LG; i++) c += (x >> i) & 1;
    return c;
  endfunction

  function automatic int m_count();
    return (m_wr - m_rd) & (M - 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // model update on every active edge using the inputs presented that cycle
  always @(posedge clk) begin
    if (rst_i) begin
      m_rd = 0;
      m_err = 1'b0;
      m_prev_gray = 0;
    end else begin
`ifdef BSG_ASYNC_PTR_GRAY_READ_CHECK_EN
      if (deq_i && m_count() == 0) m_err = 1'b1;
      if (popcount(int'(w_gray_i) ^ m_prev_gray) > 1) m_err = 1'b1;
      if (m_count() > H) m_err = 1'b1;
      m_prev_gray = int'(w_gray_i);
`endif
      if (deq_i && m_count() != 0) m_rd = (m_rd + 1) & (M - 1);
    end
  end

  // scoreboard: expected output vector per cycle pushed and popped on the spot
  logic [4*LG+1:0] exp_q[$];
  always @(negedge clk) begin
    logic [4*LG+1:0] e;
    if (chk_en && !rst_i) begin
      exp_q.push_back({(m_count() != 0), LG'(m_count()), LG'(m_rd), LG'(gray_of(m_rd)),
                       LG'(m_rd % H), m_err});
      e = exp_q.pop_front();
      check("valid", int'(valid_o), int'(e[4*LG+1]));
      check("count", int'(count_o), int'(e[4*LG:3*LG+1]));
      check("bin",   int'(bin_o),   int'(e[3*LG:2*LG+1]));
      check("gray",  int'(gray_o),  int'(e[2*LG:LG+1]));
      check("addr",  int'(addr_o),  int'(e[LG-1:1]));
      check("error", int'(error_o), int'(e[0]));
    end
  end

  // driver tasks: inputs change 1 time unit after the active edge
  task automatic set_wr(input int b);
    m_wr = b & (M - 1);
    w_gray_i = LG'(gray_of(m_wr));
  endtask

  task automatic cyc(input bit rst, input bit deq);
    rst_i = rst;
    deq_i = deq;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    rst_i = 1'b0;
    deq_i = 1'b0;
  endtask

  bit exp_err_en;

  initial begin
`ifdef BSG_ASYNC_PTR_GRAY_READ_CHECK_EN
    exp_err_en = 1'b1;
`else
    exp_err_en = 1'b0;
`endif
    rst_i = 1'b1;
    deq_i = 1'b0;
    w_gray_i = '0;
    @(posedge clk);
    #1;
    set_wr(0);
    do_reset();
    chk_en = 1'b1;
    #2;
    // reset state with write pointer 00000
    check("rst_valid", int'(valid_o), 0);
    check("rst_count", int'(count_o), 0);
    check("rst_bin",   int'(bin_o), 0);
    check("rst_gray",  int'(gray_o), 0);
    check("rst_addr",  int'(addr_o), 0);
    check("rst_err",   int'(error_o), 0);
    @(posedge clk); #1;

    // three entries drained: counts 3,2,1,0 and gray 00001,00011,00010
    set_wr(3);
    #2;
    check("t3_gray_in", int'(w_gray_i), 5'b00010);
    check("t3_count0", int'(count_o), 3);
    cyc(1'b0, 1'b1); #2;
    check("t3_bin1", int'(bin_o), 1); check("t3_gray1", int'(gray_o), 5'b00001);
    check("t3_count1", int'(count_o), 2);
    cyc(1'b0, 1'b1); #2;
    check("t3_bin2", int'(bin_o), 2); check("t3_gray2", int'(gray_o), 5'b00011);
    check("t3_count2", int'(count_o), 1);
    cyc(1'b0, 1'b1); #2;
    check("t3_bin3", int'(bin_o), 3); check("t3_gray3", int'(gray_o), 5'b00010);
    check("t3_count3", int'(count_o), 0); check("t3_valid3", int'(valid_o), 0);

    // dequeue while empty: pointers hold, error only with checking enabled
    cyc(1'b0, 1'b1);
    deq_i = 1'b0;
    #2;
    check("empty_bin", int'(bin_o), 3);
    check("empty_err", int'(error_o), int'(exp_err_en));
    cyc(1'b0, 1'b0); #2;
    check("empty_err_sticky", int'(error_o), int'(exp_err_en));

    // two-bit jump on the write pointer 00000 -> 00011
    set_wr(0);
    do_reset();
    set_wr(2);
    #2;
    check("jump_gray_in", int'(w_gray_i), 5'b00011);
    cyc(1'b0, 1'b0); #2;
    check("jump_err", int'(error_o), int'(exp_err_en));

    // full FIFO: write pointer 11000 (binary 16) against read pointer 0
    set_wr(0);
    do_reset();
    set_wr(16);
    #2;
    check("full_gray_in", int'(w_gray_i), 5'b11000);
    check("full_count", int'(count_o), 16);
    check("full_valid", int'(valid_o), 1);
    check("full_err", int'(error_o), 0);

    // stream 40 entries, one gray step per cycle, dequeue every cycle
    set_wr(0);
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      set_wr(i);
      cyc(1'b0, 1'b1);
      #2;
      if (i == 31) begin
        check("wrap_bin31", int'(bin_o), 31);
        check("wrap_gray31", int'(gray_o), 5'b10000);
        check("wrap_addr15", int'(addr_o), 15);
      end
      if (i == 32) begin
        check("wrap_bin0", int'(bin_o), 0);
        check("wrap_gray0", int'(gray_o), 0);
        check("wrap_addr0", int'(addr_o), 0);
      end
    end
    check("stream_err", int'(error_o), 0);

    // reset during an active dequeue at pointer 7
    set_wr(0);
    do_reset();
    set_wr(10);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1);
    #2;
    check("p7_bin", int'(bin_o), 7);
    cyc(1'b1, 1'b1);
    deq_i = 1'b0;
    rst_i = 1'b0;
    #2;
    check("rst_mid_bin", int'(bin_o), 0);
    check("rst_mid_gray", int'(gray_o), 0);
    cyc(1'b0, 1'b1);
    deq_i = 1'b0;
    #2;
    check("rst_mid_addr", int'(addr_o), 1);

    // random traffic: the write side advances at most one step and never overfills
    set_wr(0);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1 && m_count() < H) set_wr(m_wr + 1);
      if ($urandom_range(0, 60) == 0) begin
        set_wr(0);
        do_reset();
      end else begin
        cyc(1'b0, 1'($urandom_range(0, 2) != 0));
      end
    end
    deq_i = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // bound on total run time
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
